add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_add_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_arbiter.sv
// ---------------------------------------------------------------------------
// add_arbiter
//
// Purpose:
//   Two-requester front end for a single shared 32-bit adder. Each requester
//   presents operand beats with a valid/ready handshake. A beat is either a
//   complete 32-bit add (single op) or one half of a 64-bit add (wide op:
//   low word first, then high word). Only one beat uses the adder per cycle.
//   The adder sum and carry are captured in a one-deep result register that
//   the consumer drains with its own valid/ready handshake.
//
//   Arbitration between simultaneous requesters is round-robin when
//   RR_EN != 0, otherwise requester 0 always wins. Once a wide op's low
//   beat is accepted, the block locks onto that requester until its high
//   beat is accepted, feeding the stored low-word carry into the high word.
//
// Parameters:
//   RR_EN       1 = round-robin between requesters, 0 = fixed priority to 0
//
// Ports:
//   clk                 clock, all state changes on the rising edge
//   clr                 asynchronous active-high reset
//   reqN_valid          requester N presents a beat (N = 0, 1)
//   reqN_ready          beat from requester N accepted this cycle
//   reqN_a, reqN_b      operand words for the beat
//   reqN_cin            carry-in, used on a first beat only
//   reqN_wide           64-bit op flag, sampled on a first beat only
//   add_ra, add_rb      operands driven to the shared adder
//   add_cin             carry-in driven to the shared adder
//   add_rc, add_cout    combinational sum and carry-out from the adder
//   res_valid           result register holds a result
//   res_ready           consumer takes the result this cycle
//   res_sum, res_cout   registered sum and carry-out
//   res_id              requester owning the result
//   res_last            1 = single op or high beat of a wide op
// ---------------------------------------------------------------------------
module add_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        clr,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_cin,
  input  logic        req0_wide,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_cin,
  input  logic        req1_wide,

  output logic [31:0] add_ra,
  output logic [31:0] add_rb,
  output logic        add_cin,
  input  logic [31:0] add_rc,
  input  logic        add_cout,

  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        res_cout,
  output logic        res_id,
  output logic        res_last
);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q,  prio_d;
  logic   carry_q, carry_d;

  logic   grant0, grant1;
  logic   take;
  logic   acc0, acc1, acc;
  logic   acc_id;
  logic   sel_wide;
  logic   first_wide;

  // A beat can only be accepted when the result register is empty or is
  // being drained in the same cycle, which gives zero-bubble streaming.
  assign take = !res_valid || res_ready;

  // Grant selection. In LOCK only the owner of the open wide op is eligible;
  // the other requester is held off even when valid. In ARB a lone valid
  // requester wins outright and a tie is broken by prio (or by fixed
  // priority to requester 0 when round-robin is disabled).
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state_q)
      ARB: begin
        if (req0_valid && req1_valid) begin
          if ((RR_EN != 0) && prio_q) begin
            grant1 = 1'b1;
          end else begin
            grant0 = 1'b1;
          end
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
      LOCK: begin
        grant0 = req0_valid && !owner_q;
        grant1 = req1_valid &&  owner_q;
      end
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  // Ready is gated by clr so nothing can be handed over while the block is
  // being reset, even though the state registers are already cleared.
  assign req0_ready = take && grant0 && !clr;
  assign req1_ready = take && grant1 && !clr;

  assign acc0   = req0_valid && req0_ready;
  assign acc1   = req1_valid && req1_ready;
  assign acc    = acc0 || acc1;
  assign acc_id = acc1;

  // The wide flag only matters on a first beat; in LOCK it is ignored.
  assign sel_wide   = acc1 ? req1_wide : req0_wide;
  assign first_wide = (state_q == ARB) && acc && sel_wide;

  // Adder drive. The accepted beat's operands go to the shared adder. A high
  // beat takes its carry from the stored low-word carry, never from the
  // requester. With no accepted beat the adder inputs are parked at zero.
  always_comb begin
    add_ra  = 32'd0;
    add_rb  = 32'd0;
    add_cin = 1'b0;
    if (acc0) begin
      add_ra  = req0_a;
      add_rb  = req0_b;
      add_cin = (state_q == LOCK) ? carry_q : req0_cin;
    end else if (acc1) begin
      add_ra  = req1_a;
      add_rb  = req1_b;
      add_cin = (state_q == LOCK) ? carry_q : req1_cin;
    end
  end

  // Next-state logic for the ARB/LOCK controller, the round-robin pointer
  // and the wide-op carry. Nothing moves without an accepted beat, so a
  // backpressured result register freezes all of this state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    carry_d = carry_q;
    if (acc) begin
      case (state_q)
        ARB: begin
          if (sel_wide) begin
            state_d = LOCK;
            owner_d = acc_id;
            carry_d = add_cout;
          end else begin
            prio_d = !acc_id;
          end
        end
        LOCK: begin
          state_d = ARB;
          prio_d  = !acc_id;
        end
        default: begin
          state_d = ARB;
        end
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ARB;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      carry_q <= carry_d;
    end
  end

  // Result register. An accepted beat always reloads it (this also covers
  // drain-and-accept in the same cycle). Without an accept, a drain empties
  // it; otherwise the held result stays untouched.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      res_valid <= 1'b0;
      res_sum   <= 32'd0;
      res_cout  <= 1'b0;
      res_id    <= 1'b0;
      res_last  <= 1'b0;
    end else if (acc) begin
      res_valid <= 1'b1;
      res_sum   <= add_rc;
      res_cout  <= add_cout;
      res_id    <= acc_id;
      res_last  <= !first_wide;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_add_arbiter
//
// Purpose:
//   Self-checking bench for add_arbiter. Two instances share all inputs: the
//   main one uses round-robin, the second uses fixed priority. Each has its
//   own behavioural 32-bit adder. Expected results are pushed into a queue
//   when a beat is driven and popped when the main instance hands a result
//   to the consumer.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_add_arbiter;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        id;
    logic        last;
  } exp_t;

  logic        clk;
  logic        clr;
  logic        req0_valid, req0_cin, req0_wide;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_cin, req1_wide;
  logic [31:0] req1_a, req1_b;
  logic        res_ready;

  logic        req0_ready, req1_ready;
  logic [31:0] add_ra, add_rb, add_rc;
  logic        add_cin, add_cout;
  logic        res_valid, res_cout, res_id, res_last;
  logic [31:0] res_sum;

  logic        fp_req0_ready, fp_req1_ready;
  logic [31:0] fp_add_ra, fp_add_rb, fp_add_rc;
  logic        fp_add_cin, fp_add_cout;
  logic        fp_res_valid, fp_res_cout, fp_res_id, fp_res_last;
  logic [31:0] fp_res_sum;

  exp_t sb[$];
  int   checks_total;
  int   checks_passed;
  logic rr_prio;

  // Behavioural shared adders, one per instance.
  assign {add_cout, add_rc}       = {1'b0, add_ra} + {1'b0, add_rb} + {32'd0, add_cin};
  assign {fp_add_cout, fp_add_rc} = {1'b0, fp_add_ra} + {1'b0, fp_add_rb} + {32'd0, fp_add_cin};

  add_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .clr(clr),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_wide(req0_wide),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_wide(req1_wide),
    .add_ra(add_ra), .add_rb(add_rb), .add_cin(add_cin), .add_rc(add_rc), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
    .res_id(res_id), .res_last(res_last)
  );

  add_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .clr(clr),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_wide(req0_wide),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_wide(req1_wide),
    .add_ra(fp_add_ra), .add_rb(fp_add_rb), .add_cin(fp_add_cin), .add_rc(fp_add_rc),
    .add_cout(fp_add_cout),
    .res_valid(fp_res_valid), .res_ready(res_ready), .res_sum(fp_res_sum),
    .res_cout(fp_res_cout), .res_id(fp_res_id), .res_last(fp_res_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic cin,
                              input logic id, input logic last);
    exp_t e;
    logic [32:0] s;
    s      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    e.sum  = s[31:0];
    e.cout = s[32];
    e.id   = id;
    e.last = last;
    return e;
  endfunction

  // Scoreboard: every result the consumer takes is compared with the oldest
  // expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      checks_total++;
      if (sb.size() == 0) begin
        $display("[TB] FAIL sb_unexpected: got sum=%h id=%0d with no expected result", res_sum, res_id);
      end else begin
        e = sb.pop_front();
        if ({res_sum, res_cout, res_id, res_last} !== e) begin
          $display("[TB] FAIL sb_result: got sum=%h cout=%0d id=%0d last=%0d, expected sum=%h cout=%0d id=%0d last=%0d",
                   res_sum, res_cout, res_id, res_last, e.sum, e.cout, e.id, e.last);
        end else begin
          checks_passed++;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_cin = 1'b0; req0_wide = 1'b0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_cin = 1'b0; req1_wide = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    res_ready = 1'b1;
    idle_inputs();
    #3;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks_total++;
    if ({req0_ready, req1_ready} !== 2'b00)
      $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    else checks_passed++;
    checks_total++;
    if ({res_valid, res_sum, res_cout, res_id, res_last} !== 36'd0)
      $display("[TB] FAIL reset_result: got valid=%0d sum=%h cout=%0d id=%0d last=%0d expected all 0",
               res_valid, res_sum, res_cout, res_id, res_last);
    else checks_passed++;
    next_cycle();
    clr = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks_total++;
    if ({add_ra, add_rb, add_cin} !== 65'd0)
      $display("[TB] FAIL idle_adder: got ra=%h rb=%h cin=%0d expected 0", add_ra, add_rb, add_cin);
    else checks_passed++;
    next_cycle();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_cin = 1'b0; req0_wide = 1'b0;
    sb.push_back(mk(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    checks_total++;
    if (req0_ready !== 1'b1)
      $display("[TB] FAIL single_ready: got %0d expected 1", req0_ready);
    else checks_passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks_total++;
    if (res_valid !== 1'b1)
      $display("[TB] FAIL single_latency: got res_valid=%0d expected 1", res_valid);
    else checks_passed++;
    next_cycle();
  endtask

  task automatic test_wide_lock();
    // prio points at requester 1 after the single op from requester 0.
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_cin = 1'b0; req1_wide = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_cin = 1'b0; req0_wide = 1'b0;
    sb.push_back(mk(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    checks_total++;
    if ({req0_ready, req1_ready} !== 2'b01)
      $display("[TB] FAIL wide_low_ready: got %b expected 01", {req0_ready, req1_ready});
    else checks_passed++;
    next_cycle();
    // Owner pauses: the lock must hold and requester 0 stays stalled.
    req1_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks_total++;
      if ({req0_ready, req1_ready} !== 2'b00)
        $display("[TB] FAIL wide_lock_hold: got %b expected 00", {req0_ready, req1_ready});
      else checks_passed++;
      next_cycle();
    end
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd3; req1_cin = 1'b0; req1_wide = 1'b1;
    sb.push_back(mk(32'd2, 32'd3, 1'b1, 1'b1, 1'b1));
    @(negedge clk);
    checks_total++;
    if ({req0_ready, req1_ready, add_cin} !== 3'b011)
      $display("[TB] FAIL wide_high_beat: got ready0,ready1,cin=%b expected 011",
               {req0_ready, req1_ready, add_cin});
    else checks_passed++;
    next_cycle();
    req1_valid = 1'b0; req1_wide = 1'b0;
    sb.push_back(mk(32'd10, 32'd20, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    checks_total++;
    if (req0_ready !== 1'b1)
      $display("[TB] FAIL wide_release: got req0_ready=%0d expected 1", req0_ready);
    else checks_passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic exp_id;
    clr = 1'b1;
    #2;
    clr = 1'b0;
    rr_prio = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h11; req0_b = 32'h22; req0_cin = 1'b0; req0_wide = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFF0; req1_b = 32'h20; req1_cin = 1'b1; req1_wide = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_id = rr_prio;
      if (exp_id) sb.push_back(mk(req1_a, req1_b, req1_cin, 1'b1, 1'b1));
      else        sb.push_back(mk(req0_a, req0_b, req0_cin, 1'b0, 1'b1));
      @(negedge clk);
      checks_total++;
      if ({req0_ready, req1_ready} !== {!exp_id, exp_id})
        $display("[TB] FAIL rr_grant: got %b expected %b", {req0_ready, req1_ready}, {!exp_id, exp_id});
      else checks_passed++;
      checks_total++;
      if ({fp_req0_ready, fp_req1_ready} !== 2'b10)
        $display("[TB] FAIL fp_grant: got %b expected 10", {fp_req0_ready, fp_req1_ready});
      else checks_passed++;
      if (i > 0) begin
        checks_total++;
        if ({fp_res_valid, fp_res_id} !== 2'b10)
          $display("[TB] FAIL fp_res_id: got valid,id=%b expected 10", {fp_res_valid, fp_res_id});
        else checks_passed++;
      end
      rr_prio = !exp_id;
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_id;
    // A result is waiting in the register; hold it for three cycles.
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks_total++;
      if ({req0_ready, req1_ready} !== 2'b00)
        $display("[TB] FAIL bp_ready: got %b expected 00", {req0_ready, req1_ready});
      else checks_passed++;
      checks_total++;
      if (sb.size() == 0 || res_valid !== 1'b1 || res_sum !== sb[0].sum)
        $display("[TB] FAIL bp_hold: got valid=%0d sum=%h expected held result", res_valid, res_sum);
      else checks_passed++;
      next_cycle();
    end
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_id = rr_prio;
      if (exp_id) sb.push_back(mk(req1_a, req1_b, req1_cin, 1'b1, 1'b1));
      else        sb.push_back(mk(req0_a, req0_b, req0_cin, 1'b0, 1'b1));
      @(negedge clk);
      checks_total++;
      if ({res_valid, req0_ready, req1_ready} !== {1'b1, !exp_id, exp_id})
        $display("[TB] FAIL bp_resume: got valid,ready0,ready1=%b expected %b",
                 {res_valid, req0_ready, req1_ready}, {1'b1, !exp_id, exp_id});
      else checks_passed++;
      rr_prio = !exp_id;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    checks_total++;
    if (res_valid !== 1'b0)
      $display("[TB] FAIL bp_drain: got res_valid=%0d expected 0", res_valid);
    else checks_passed++;
    next_cycle();
  endtask

  task automatic test_clr_mid_op();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_cin = 1'b0; req0_wide = 1'b1;
    @(negedge clk);
    checks_total++;
    if (req0_ready !== 1'b1)
      $display("[TB] FAIL clr_low_ready: got %0d expected 1", req0_ready);
    else checks_passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks_total++;
    if ({res_valid, res_sum, res_cout, res_last} !== {1'b1, 32'd0, 1'b1, 1'b0})
      $display("[TB] FAIL clr_low_result: got valid=%0d sum=%h cout=%0d last=%0d expected 1/0/1/0",
               res_valid, res_sum, res_cout, res_last);
    else checks_passed++;
    next_cycle();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_cin = 1'b0; req0_wide = 1'b0;
    clr = 1'b1;
    #2;
    checks_total++;
    if ({res_valid, req0_ready} !== 2'b00)
      $display("[TB] FAIL clr_async: got valid,ready0=%b expected 00", {res_valid, req0_ready});
    else checks_passed++;
    clr = 1'b0;
    res_ready = 1'b1;
    sb.push_back(mk(32'd5, 32'd7, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    checks_total++;
    if ({req0_ready, add_cin} !== 2'b10)
      $display("[TB] FAIL clr_first_beat: got ready0,cin=%b expected 10", {req0_ready, add_cin});
    else checks_passed++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    next_cycle();
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rr_prio       = 1'b0;
    test_reset();
    test_single();
    test_wide_lock();
    test_round_robin();
    test_back_to_back();
    test_clr_mid_op();
    repeat (2) next_cycle();
    checks_total++;
    if (sb.size() != 0)
      $display("[TB] FAIL sb_empty: got %0d pending results expected 0", sb.size());
    else checks_passed++;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
